// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types, scan-code/HID constants and key mapping for the PS/2 keycode decoder
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_t;

  localparam logic [7:0] SC_E0    = 8'hE0;
  localparam logic [7:0] SC_F0    = 8'hF0;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  localparam logic [7:0] HID_NONE  = 8'h00;
  localparam logic [7:0] HID_W     = 8'h1A;
  localparam logic [7:0] HID_A     = 8'h04;
  localparam logic [7:0] HID_S     = 8'h16;
  localparam logic [7:0] HID_D     = 8'h07;
  localparam logic [7:0] HID_SPACE = 8'h2C;
  localparam logic [7:0] HID_ENTER = 8'h28;
  localparam logic [7:0] HID_UP    = 8'h52;
  localparam logic [7:0] HID_DOWN  = 8'h51;
  localparam logic [7:0] HID_LEFT  = 8'h50;
  localparam logic [7:0] HID_RIGHT = 8'h4F;

  // Unmapped codes return HID_NONE so the caller can ignore them.
  function automatic logic [7:0] sc_to_hid(input logic ext, input logic [7:0] code);
    logic [7:0] usage;
    usage = HID_NONE;
    case ({ext, code})
      {1'b0, SC_W}:     usage = HID_W;
      {1'b0, SC_A}:     usage = HID_A;
      {1'b0, SC_S}:     usage = HID_S;
      {1'b0, SC_D}:     usage = HID_D;
      {1'b0, SC_SPACE}: usage = HID_SPACE;
      {1'b0, SC_ENTER}: usage = HID_ENTER;
      {1'b1, SC_UP}:    usage = HID_UP;
      {1'b1, SC_DOWN}:  usage = HID_DOWN;
      {1'b1, SC_LEFT}:  usage = HID_LEFT;
      {1'b1, SC_RIGHT}: usage = HID_RIGHT;
      default:          usage = HID_NONE;
    endcase
    return usage;
  endfunction

endpackage

// File: rtl/ps2_keycode_decoder_if.sv
// rtl/ps2_keycode_decoder_if.sv - PS/2 pins and keycode outputs bundled for the decoder
interface ps2_keycode_decoder_if;
  logic       PS2_CLK;
  logic       PS2_DAT;
  logic [7:0] keycode;
  logic       key_pressed;
  logic       rx_error;

  modport master (
    output PS2_CLK, PS2_DAT,
    input  keycode, key_pressed, rx_error
  );

  modport slave (
    input  PS2_CLK, PS2_DAT,
    output keycode, key_pressed, rx_error
  );
endinterface

// File: rtl/ps2_byte_rx.sv
// rtl/ps2_byte_rx.sv - PS/2 pin synchronizer, clock filter, byte framing FSM and frame timeout
module ps2_byte_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_dat,
  output logic       o_byte_valid,
  output logic [7:0] o_byte_data,
  output logic       o_rx_error
);

  localparam int FCNT_W = $clog2(FILTER_LEN + 1);
  localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FILTER_LEN - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

  logic              r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic              r_filt, r_filt_d;
  logic [FCNT_W-1:0] r_fcnt;
  rx_state_t         r_state, w_state_nxt;
  logic [7:0]        r_shift, w_shift_nxt;
  logic [2:0]        r_bit_cnt, w_bit_cnt_nxt;
  logic              r_par, w_par_nxt;
  logic [TMO_W-1:0]  r_tmo, w_tmo_nxt;
  logic              r_byte_valid, w_byte_valid_nxt;
  logic              r_rx_error, w_rx_error_nxt;
  logic              w_sample;

  // Filtered clock only follows the pin after FILTER_LEN agreeing samples.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
      r_filt   <= 1'b1;
      r_filt_d <= 1'b1;
      r_fcnt   <= '0;
    end else begin
      r_clk_s1 <= i_ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= i_ps2_dat;
      r_dat_s2 <= r_dat_s1;
      r_filt_d <= r_filt;
      if (r_clk_s2 != r_filt) begin
        if (r_fcnt == FCNT_LAST) begin
          r_filt <= r_clk_s2;
          r_fcnt <= '0;
        end else begin
          r_fcnt <= r_fcnt + FCNT_W'(1);
        end
      end else begin
        r_fcnt <= '0;
      end
    end
  end

  assign w_sample = r_filt_d & ~r_filt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_par        <= 1'b0;
      r_tmo        <= '0;
      r_byte_valid <= 1'b0;
      r_rx_error   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_shift      <= w_shift_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_par        <= w_par_nxt;
      r_tmo        <= w_tmo_nxt;
      r_byte_valid <= w_byte_valid_nxt;
      r_rx_error   <= w_rx_error_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_shift_nxt      = r_shift;
    w_bit_cnt_nxt    = r_bit_cnt;
    w_par_nxt        = r_par;
    w_byte_valid_nxt = 1'b0;
    w_rx_error_nxt   = 1'b0;
    w_tmo_nxt        = (r_state == ST_IDLE) ? '0 : r_tmo + TMO_W'(1);
    if (w_sample) begin
      w_tmo_nxt = '0;
      case (r_state)
        ST_IDLE: begin
          if (!r_dat_s2) begin
            w_state_nxt   = ST_DATA;
            w_bit_cnt_nxt = '0;
          end
        end
        ST_DATA: begin
          w_shift_nxt   = {r_dat_s2, r_shift[7:1]};
          w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) w_state_nxt = ST_PARITY;
        end
        ST_PARITY: begin
          w_par_nxt   = r_dat_s2;
          w_state_nxt = ST_STOP;
        end
        ST_STOP: begin
          if (r_dat_s2 && (^{r_shift, r_par})) w_byte_valid_nxt = 1'b1;
          else                                 w_rx_error_nxt   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end else if (r_state != ST_IDLE && r_tmo == TMO_LAST) begin
      w_rx_error_nxt = 1'b1;
      w_state_nxt    = ST_IDLE;
      w_tmo_nxt      = '0;
    end
  end

  assign o_byte_valid = r_byte_valid;
  assign o_byte_data  = r_shift;
  assign o_rx_error   = r_rx_error;

endmodule

// File: rtl/ps2_keycode_decoder.sv
// rtl/ps2_keycode_decoder.sv - PS/2 set-2 receiver translating held keys into HID usage codes
module ps2_keycode_decoder
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                 Clk,
  input  logic                 Reset,
  ps2_keycode_decoder_if.slave bus
);

  logic       w_byte_valid, w_rx_error;
  logic [7:0] w_byte_data, w_usage;
  logic       r_ext, r_brk, r_key_pressed;
  logic [7:0] r_keycode;

  ps2_byte_rx #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_byte_rx (
    .i_clk        (Clk),
    .i_rst        (Reset),
    .i_ps2_clk    (bus.PS2_CLK),
    .i_ps2_dat    (bus.PS2_DAT),
    .o_byte_valid (w_byte_valid),
    .o_byte_data  (w_byte_data),
    .o_rx_error   (w_rx_error)
  );

  assign w_usage = sc_to_hid(r_ext, w_byte_data);

  // Releasing a key other than the one shown leaves the display alone.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_ext         <= 1'b0;
      r_brk         <= 1'b0;
      r_keycode     <= HID_NONE;
      r_key_pressed <= 1'b0;
    end else begin
      r_key_pressed <= 1'b0;
      if (w_rx_error) begin
        r_ext <= 1'b0;
        r_brk <= 1'b0;
      end else if (w_byte_valid) begin
        if (w_byte_data == SC_E0) begin
          r_ext <= 1'b1;
        end else if (w_byte_data == SC_F0) begin
          r_brk <= 1'b1;
        end else begin
          r_ext <= 1'b0;
          r_brk <= 1'b0;
          if (w_usage != HID_NONE) begin
            if (r_brk) begin
              if (w_usage == r_keycode) r_keycode <= HID_NONE;
            end else begin
              r_keycode     <= w_usage;
              r_key_pressed <= (w_usage != r_keycode);
            end
          end
        end
      end
    end
  end

  assign bus.keycode     = r_keycode;
  assign bus.key_pressed = r_key_pressed;
  assign bus.rx_error    = w_rx_error;

endmodule
